core_run_ctrl: RTL and testbench

Run controller for the single-cycle RV32I core. It holds the core in reset while a program image streams into instruction memory through the core's `inst_wen`/`inst_addr`/`inst_data` port. It then releases reset and gates the core's `enb` to run continuously, for a fixed cycle budget, or one cycle at a time. It sits between the host/testbench stream and the core top level, and is the only driver of the core's `rst`, `enb` and instruction-write port.

---
 rtl/core_run_pkg.sv | 20 ++
 rtl/core_run_ctrl_budget.sv | 27 ++
 rtl/core_run_ctrl.sv | 137 +++++++++++++
 tb/tb_core_run_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_pkg.sv
// Shared state encoding and default geometry for the core run controller.
package core_run_pkg;

  localparam int IMEM_WORDS_DEFAULT = 128;
  localparam int ADDR_W_DEFAULT     = 7;
  localparam int BUDGET_W_DEFAULT   = 16;

  // A run budget of zero means run until told to stop.
  localparam int UNBOUNDED_BUDGET = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_HALT,
    ST_RUN,
    ST_STEP
  } run_state_t;

endpackage

// File: rtl/core_run_ctrl_budget.sv
// run_budget_cnt: loadable down-counter for bounded runs; saturates at zero and
// flags the final budgeted cycle.
module run_budget_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: streams a program image into the core's instruction memory
// under reset, then gates the core's enb for free runs, budgeted runs or steps.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int BUDGET_W   = BUDGET_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [31:0]         s_data,
  input  logic                s_last,
  input  logic                cmd_load,
  input  logic                cmd_run,
  input  logic                cmd_step,
  input  logic                cmd_halt,
  input  logic [BUDGET_W-1:0] run_cycles,
  output logic                inst_wen,
  output logic [ADDR_W-1:0]   inst_addr,
  output logic [31:0]         inst_data,
  output logic                core_rst,
  output logic                enb,
  output logic                done,
  output logic                load_err,
  output logic [7:0]          words_loaded,
  output logic [31:0]         cycles_run
);

  localparam logic [7:0] LAST_IDX = 8'(IMEM_WORDS - 1);

  run_state_t          state;
  run_state_t          next_state;
  logic                handshake;
  logic                finish_done;
  logic                budget_load;
  logic                budget_last;
  logic                run_expired;
  logic [BUDGET_W-1:0] budget_count;

  assign s_ready     = (state == ST_LOAD);
  assign handshake   = s_valid && s_ready;
  assign budget_load = (state == ST_HALT) && cmd_run && !cmd_load;
  assign run_expired = (budget_count != BUDGET_W'(UNBOUNDED_BUDGET)) && budget_last;

  run_budget_cnt #(
    .W(BUDGET_W)
  ) u_budget (
    .clk  (clk),
    .rst  (rst),
    .load (budget_load),
    .value(run_cycles),
    .dec  (state == ST_RUN),
    .count(budget_count),
    .last (budget_last)
  );

  // Budget expiry outranks cmd_halt so a halt in the final cycle still pulses done.
  always_comb begin
    next_state  = state;
    finish_done = 1'b0;
    case (state)
      ST_IDLE:  next_state = ST_LOAD;
      ST_LOAD: begin
        if (handshake && (s_last || (words_loaded == LAST_IDX))) begin
          next_state = ST_CLEAR;
        end
      end
      ST_CLEAR: next_state = ST_HALT;
      ST_HALT: begin
        if (cmd_load) begin
          next_state = ST_IDLE;
        end else if (cmd_run) begin
          next_state = ST_RUN;
        end else if (cmd_step) begin
          next_state = ST_STEP;
        end
      end
      ST_RUN: begin
        if (cmd_load) begin
          next_state = ST_IDLE;
        end else if (run_expired) begin
          next_state  = ST_HALT;
          finish_done = 1'b1;
        end else if (cmd_halt) begin
          next_state = ST_HALT;
        end
      end
      ST_STEP: begin
        next_state  = ST_HALT;
        finish_done = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs follow the state being entered, so enb and core_rst change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      core_rst     <= 1'b1;
      enb          <= 1'b0;
      inst_wen     <= 1'b0;
      inst_addr    <= '0;
      inst_data    <= '0;
      done         <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      cycles_run   <= '0;
    end else begin
      state    <= next_state;
      core_rst <= (next_state inside {ST_IDLE, ST_LOAD, ST_CLEAR});
      enb      <= (next_state inside {ST_RUN, ST_STEP});
      done     <= finish_done;
      inst_wen <= handshake;
      if (handshake) begin
        inst_addr    <= words_loaded[ADDR_W-1:0];
        inst_data    <= s_data;
        words_loaded <= words_loaded + 8'd1;
        if ((words_loaded == LAST_IDX) && !s_last) begin
          load_err <= 1'b1;
        end
      end
      if (enb) begin
        cycles_run <= cycles_run + 32'd1;
      end
      if ((next_state == ST_IDLE) && (state != ST_IDLE)) begin
        words_loaded <= '0;
        load_err     <= 1'b0;
        cycles_run   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized scenario bench for core_run_ctrl with a write scoreboard,
// enb/done pulse counters and a tiny probed-PC model of the loaded program.
module tb_core_run_ctrl;

  localparam int IMEM_WORDS = 128;
  localparam int ADDR_W     = 7;
  localparam int BUDGET_W   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [31:0]         s_data;
  logic                s_last;
  logic                cmd_load;
  logic                cmd_run;
  logic                cmd_step;
  logic                cmd_halt;
  logic [BUDGET_W-1:0] run_cycles;
  logic                inst_wen;
  logic [ADDR_W-1:0]   inst_addr;
  logic [31:0]         inst_data;
  logic                core_rst;
  logic                enb;
  logic                done;
  logic                load_err;
  logic [7:0]          words_loaded;
  logic [31:0]         cycles_run;

  core_run_ctrl #(
    .IMEM_WORDS(IMEM_WORDS),
    .ADDR_W    (ADDR_W),
    .BUDGET_W  (BUDGET_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .cmd_load    (cmd_load),
    .cmd_run     (cmd_run),
    .cmd_step    (cmd_step),
    .cmd_halt    (cmd_halt),
    .run_cycles  (run_cycles),
    .inst_wen    (inst_wen),
    .inst_addr   (inst_addr),
    .inst_data   (inst_data),
    .core_rst    (core_rst),
    .enb         (enb),
    .done        (done),
    .load_err    (load_err),
    .words_loaded(words_loaded),
    .cycles_run  (cycles_run)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int enb_cnt = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       img[$];
  logic [31:0]       exp_cycles;
  logic [31:0]       pc_model;

  always @(negedge clk) begin
    if (inst_wen === 1'b1) begin
      wr_addr_q.push_back(inst_addr);
      wr_data_q.push_back(inst_data);
    end
    if (enb === 1'b1) enb_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // Stand-in for the core's PC running the 3-word image (word 2 jumps to itself).
  always @(posedge clk) begin
    if (core_rst === 1'b1) pc_model <= 32'd0;
    else if (enb === 1'b1) pc_model <= (pc_model == 32'd8) ? 32'd8 : pc_model + 32'd4;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_check(input string tag, input int hold);
    logic [84:0] obs;
    rst = 1'b1; cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (hold) tick();
    obs = {core_rst, enb, inst_wen, inst_addr, inst_data, done, load_err,
           words_loaded, cycles_run, s_ready};
    checks++;
    if (obs !== {1'b1, 84'd0}) begin
      errors++;
      $display("[TB] FAIL %s_values: observed %h expected %h", tag, obs, {1'b1, 84'd0});
    end
    rst = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_idle: s_ready %b core_rst %b expected 0 1", tag, s_ready, core_rst);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_load: s_ready %b core_rst %b expected 1 1", tag, s_ready, core_rst);
    end
    exp_cycles = 32'd0;
  endtask

  task automatic test_reset();
    reset_and_check("reset", 2);
  endtask

  task automatic stream_image(input string tag, input bit mark_last);
    int idx = 0;
    int guard = 0;
    bit hs;
    logic exp_err;
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_err = (!mark_last && img.size() == IMEM_WORDS) ? 1'b1 : 1'b0;
    while (idx < img.size() && guard < 4000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = s_valid ? img[idx] : $urandom;
      s_last  = mark_last && (idx == img.size() - 1);
      hs = s_valid && s_ready;
      tick();
      guard++;
      if (hs) idx++;
    end
    checks++;
    if (idx != img.size()) begin
      errors++;
      $display("[TB] FAIL %s_timeout: accepted %0d expected %0d", tag, idx, img.size());
    end
    s_valid = 1'b1; s_data = $urandom; s_last = 1'b0;
    checks++;
    if (core_rst !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_clear: core_rst %b s_ready %b expected 1 0", tag, core_rst, s_ready);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0 || enb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_release: core_rst %b enb %b expected 0 0", tag, core_rst, enb);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (wr_addr_q.size() != img.size()) begin
      errors++;
      $display("[TB] FAIL %s_wcount: writes %0d expected %0d", tag, wr_addr_q.size(), img.size());
    end
    for (int k = 0; k < img.size() && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== ADDR_W'(k) || wr_data_q[k] !== img[k]) begin
        errors++;
        $display("[TB] FAIL %s_write%0d: addr %0d data %h expected addr %0d data %h",
                 tag, k, wr_addr_q[k], wr_data_q[k], k, img[k]);
      end
    end
    checks++;
    if (words_loaded !== 8'(img.size())) begin
      errors++;
      $display("[TB] FAIL %s_words: observed %0d expected %0d", tag, words_loaded, img.size());
    end
    checks++;
    if (load_err !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s_err: observed %b expected %b", tag, load_err, exp_err);
    end
  endtask

  task automatic reload(input string tag);
    cmd_load = 1'b1;
    cmd_run  = 1'($urandom_range(0, 1));
    cmd_step = 1'($urandom_range(0, 1));
    cmd_halt = 1'($urandom_range(0, 1));
    run_cycles = BUDGET_W'($urandom);
    tick();
    cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    checks++;
    if ({core_rst, enb, words_loaded, load_err, cycles_run} !== {1'b1, 1'b0, 8'd0, 1'b0, 32'd0}) begin
      errors++;
      $display("[TB] FAIL %s_reload: rst %b enb %b words %0d err %b cycles %0d expected 1 0 0 0 0",
               tag, core_rst, enb, words_loaded, load_err, cycles_run);
    end
    exp_cycles = 32'd0;
  endtask

  task automatic test_load_fixed();
    img.delete();
    img.push_back(32'h00500093);
    img.push_back(32'h00108113);
    img.push_back(32'h0000006F);
    stream_image("load3", 1'b1);
  endtask

  task automatic test_step();
    int e0 = enb_cnt;
    int d0 = done_cnt;
    for (int s = 0; s < 2; s++) begin
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      checks++;
      if (enb !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL step%0d_on: enb %b done %b expected 1 0", s, enb, done);
      end
      tick();
      checks++;
      if (enb !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("[TB] FAIL step%0d_off: enb %b done %b expected 0 1", s, enb, done);
      end
      repeat ($urandom_range(1, 3)) tick();
      exp_cycles = exp_cycles + 32'd1;
    end
    checks++;
    if (enb_cnt - e0 != 2 || done_cnt - d0 != 2) begin
      errors++;
      $display("[TB] FAIL step_counts: enb %0d done %0d expected 2 2", enb_cnt - e0, done_cnt - d0);
    end
    checks++;
    if (pc_model !== 32'd8) begin
      errors++;
      $display("[TB] FAIL step_pc: observed %0d expected 8", pc_model);
    end
  endtask

  // halt_at = 0 means no cmd_halt; otherwise cmd_halt is sampled halt_at edges after cmd_run.
  task automatic test_run(input string tag, input int n, input int halt_at);
    int e0 = enb_cnt;
    int d0 = done_cnt;
    int exp_enb;
    int limit;
    logic exp_done;
    if (n == 0) exp_enb = halt_at;
    else if (halt_at != 0 && halt_at < n) exp_enb = halt_at;
    else exp_enb = n;
    exp_done = (n != 0) && (halt_at == 0 || halt_at >= n);
    limit = ((halt_at > n) ? halt_at : n) + 3;
    cmd_run = 1'b1;
    cmd_step = 1'($urandom_range(0, 1));
    run_cycles = BUDGET_W'(n);
    tick();
    cmd_run = 1'b0; cmd_step = 1'b0;
    run_cycles = BUDGET_W'($urandom);
    checks++;
    if (enb !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_start: enb %b expected 1", tag, enb);
    end
    for (int k = 1; k <= limit; k++) begin
      if (halt_at != 0 && k == halt_at) cmd_halt = 1'b1;
      tick();
      cmd_halt = 1'b0;
      if (k == exp_enb) begin
        checks++;
        if (enb !== 1'b0 || done !== exp_done) begin
          errors++;
          $display("[TB] FAIL %s_end: enb %b done %b expected 0 %b", tag, enb, done, exp_done);
        end
      end
    end
    exp_cycles = exp_cycles + 32'(exp_enb);
    checks++;
    if (enb_cnt - e0 != exp_enb || done_cnt - d0 != int'(exp_done)) begin
      errors++;
      $display("[TB] FAIL %s_counts: enb %0d done %0d expected %0d %0d",
               tag, enb_cnt - e0, done_cnt - d0, exp_enb, exp_done);
    end
    checks++;
    if (cycles_run !== exp_cycles || core_rst !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_cycles: cycles_run %0d core_rst %b expected %0d 0",
               tag, cycles_run, core_rst, exp_cycles);
    end
  endtask

  task automatic test_bounded_run();
    test_run("run5", 5, 0);
    test_run("run1", 1, 0);
    for (int i = 0; i < 3; i++) test_run($sformatf("runrand%0d", i), $urandom_range(2, 20), 0);
  endtask

  task automatic test_unbounded_halt();
    test_run("free10", 0, 10);
    test_run("freerand", 0, $urandom_range(1, 30));
  endtask

  task automatic test_halt_edges();
    int n = $urandom_range(3, 15);
    test_run("halt_last", n, n);
    test_run("halt_early", n, $urandom_range(1, n - 1));
  endtask

  task automatic test_random_load();
    reload("rand");
    img.delete();
    repeat ($urandom_range(1, 40)) img.push_back($urandom);
    stream_image("randload", 1'b1);
    test_run("randrun", $urandom_range(1, 12), 0);
  endtask

  task automatic test_overflow();
    reload("ovf");
    img.delete();
    repeat (IMEM_WORDS) img.push_back($urandom);
    stream_image("overflow", 1'b0);
    reload("after_ovf");
    img.delete();
    repeat ($urandom_range(1, 8)) img.push_back($urandom);
    stream_image("after_ovf", 1'b1);
  endtask

  task automatic test_reset_mid_run();
    cmd_run = 1'b1;
    run_cycles = BUDGET_W'(100);
    tick();
    cmd_run = 1'b0;
    repeat ($urandom_range(5, 40)) tick();
    checks++;
    if (enb !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_running: enb %b expected 1", enb);
    end
    reset_and_check("midrun", 1);
    img.delete();
    repeat (4) img.push_back($urandom);
    stream_image("post_reset", 1'b1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
    cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
    run_cycles = '0;
    exp_cycles = 32'd0;
    test_reset();
    test_load_fixed();
    test_step();
    test_bounded_run();
    test_unbounded_halt();
    test_halt_edges();
    test_random_load();
    test_overflow();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
